// File: rtl/branch_addr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_ctrl_pkg
// Description : Shared types and helpers for the branch-address controller:
//               FSM state encoding, grant-source encoding and counter sizing.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package branch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRIVE   = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

  typedef enum logic {
    SRC_BR  = 1'b0,
    SRC_IRQ = 1'b1
  } src_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int width;
    int rem;
    width = 0;
    rem   = value - 1;
    while (rem > 0) begin
      width = width + 1;
      rem   = rem >> 1;
    end
    return width;
  endfunction

  // Bits needed to hold 0..max_count, never less than one.
  function automatic int cnt_width(input int max_count);
    int width;
    width = clog2(max_count + 1);
    return (width < 1) ? 1 : width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_addr_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_addr_ctrl_if
// Description : Bundle between the branch-address controller and its
//               neighbours (branch unit, interrupt unit, address register,
//               PC and pipeline).
// Ports       : br_req/br_target/br_ack    branch unit request + grant
//               irq_req/irq_vector/irq_ack interrupt unit request + grant
//               reg_ce/reg_d/reg_cs        address register control
//               pc_load/pc_ack             PC load handshake
//               flush/busy/err             status
//               modport slave  : controller side
//               modport master : environment side
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_addr_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              br_req;
  logic [ADDR_W-1:0] br_target;
  logic              irq_req;
  logic [ADDR_W-1:0] irq_vector;
  logic              br_ack;
  logic              irq_ack;
  logic              reg_ce;
  logic [ADDR_W-1:0] reg_d;
  logic              reg_cs;
  logic              pc_load;
  logic              pc_ack;
  logic              flush;
  logic              busy;
  logic              err;

  modport slave (
    input  br_req, br_target, irq_req, irq_vector, pc_ack,
    output br_ack, irq_ack, reg_ce, reg_d, reg_cs, pc_load, flush, busy, err
  );

  modport master (
    output br_req, br_target, irq_req, irq_vector, pc_ack,
    input  br_ack, irq_ack, reg_ce, reg_d, reg_cs, pc_load, flush, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/branch_addr_ctrl_tick_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : tick_down_counter
// Description : Loadable down-counter that only moves on Tick; saturates at
//               zero and reports it on a zero flag.
// Ports       : clk, rst (async, active-high), tick (clock enable),
//               load/load_val (load has priority), dec (count down),
//               zero (count == 0)
// Revision    : 1.0 - initial release
// ============================================================================
module tick_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (tick) begin
      if (load) begin
        r_count <= load_val;
      end else if (dec && (r_count != '0)) begin
        r_count <= r_count - WIDTH'(1);
      end
    end
  end

  assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/branch_addr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_addr_ctrl
// Description : Arbitrates branch-target and interrupt-vector requests,
//               loads the winner into the branch-address register, drives it
//               onto the PC bus until the PC acknowledges, then flushes the
//               pipeline for FLUSH_CYCLES Ticks. Interrupts win ties.
// Ports       : clk   system clock, rising edge
//               rst   asynchronous active-high reset
//               tick  global clock enable
//               bus   branch_addr_ctrl_if.slave (requests, register control,
//                     PC handshake, flush/busy/err status)
// Revision    : 1.0 - initial release
// ============================================================================
module branch_addr_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int FLUSH_CYCLES = 2,
  parameter int ACK_TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  branch_addr_ctrl_if.slave   bus
);

  // Both counters are loaded with (ticks - 1) and the terminal tick is the one
  // seen with the counter already at zero, so DRIVE lasts at most ACK_TIMEOUT
  // Ticks and FLUSH lasts exactly FLUSH_CYCLES Ticks.
  localparam bit C_FLUSH_EN  = (FLUSH_CYCLES > 0);
  localparam int C_FLUSH_MAX = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;
  localparam int C_FLUSH_W   = cnt_width(C_FLUSH_MAX);
  localparam int C_TO_MAX    = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;
  localparam int C_TO_W      = cnt_width(C_TO_MAX);
  localparam logic [C_TO_W-1:0] C_TO_LOAD = C_TO_W'(C_TO_MAX);

  state_t            r_state;
  src_t              r_src;
  logic [ADDR_W-1:0] r_reg_d;
  logic              r_reg_ce;
  logic              r_reg_cs;
  logic              r_pc_load;
  logic              r_flush;
  logic              r_busy;
  logic              r_err;

  logic              w_to_load;
  logic              w_to_dec;
  logic              w_to_zero;
  logic              w_fl_zero;

  // Timeout counter is armed while CAPTURE hands over to DRIVE.
  assign w_to_load = (r_state == ST_CAPTURE);
  assign w_to_dec  = (r_state == ST_DRIVE) && !bus.pc_ack;

  tick_down_counter #(
    .WIDTH (C_TO_W)
  ) u_timeout_cnt (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .load     (w_to_load),
    .load_val (C_TO_LOAD),
    .dec      (w_to_dec),
    .zero     (w_to_zero)
  );

  generate
    if (C_FLUSH_EN) begin : g_flush_cnt
      localparam logic [C_FLUSH_W-1:0] C_FLUSH_LOAD = C_FLUSH_W'(C_FLUSH_MAX);
      logic w_fl_load;
      logic w_fl_dec;

      assign w_fl_load = (r_state == ST_DRIVE) && bus.pc_ack;
      assign w_fl_dec  = (r_state == ST_FLUSH);

      tick_down_counter #(
        .WIDTH (C_FLUSH_W)
      ) u_flush_cnt (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .load     (w_fl_load),
        .load_val (C_FLUSH_LOAD),
        .dec      (w_fl_dec),
        .zero     (w_fl_zero)
      );
    end else begin : g_no_flush_cnt
      // FLUSH is never entered in this build.
      assign w_fl_zero = 1'b1;
    end
  endgenerate

  // Single FSM; every output except the acks is registered alongside the
  // state so that it changes on the same Tick edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_src     <= SRC_BR;
      r_reg_d   <= '0;
      r_reg_ce  <= 1'b0;
      r_reg_cs  <= 1'b1;
      r_pc_load <= 1'b0;
      r_flush   <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else if (tick) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.irq_req) begin
            r_reg_d  <= bus.irq_vector;
            r_src    <= SRC_IRQ;
            r_state  <= ST_CAPTURE;
            r_reg_ce <= 1'b1;
            r_busy   <= 1'b1;
          end else if (bus.br_req) begin
            r_reg_d  <= bus.br_target;
            r_src    <= SRC_BR;
            r_state  <= ST_CAPTURE;
            r_reg_ce <= 1'b1;
            r_busy   <= 1'b1;
          end
        end

        ST_CAPTURE: begin
          r_state   <= ST_DRIVE;
          r_reg_ce  <= 1'b0;
          r_reg_cs  <= 1'b0;
          r_pc_load <= 1'b1;
        end

        ST_DRIVE: begin
          if (bus.pc_ack) begin
            r_reg_cs  <= 1'b1;
            r_pc_load <= 1'b0;
            if (C_FLUSH_EN) begin
              r_state <= ST_FLUSH;
              r_flush <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else if (w_to_zero) begin
            // PC never answered: release the bus and carry on, flagging err.
            r_reg_cs  <= 1'b1;
            r_pc_load <= 1'b0;
            r_err     <= 1'b1;
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
          end
        end

        ST_FLUSH: begin
          if (w_fl_zero) begin
            r_state <= ST_IDLE;
            r_flush <= 1'b0;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_reg_ce  <= 1'b0;
          r_reg_cs  <= 1'b1;
          r_pc_load <= 1'b0;
          r_flush   <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  // Acks are Tick-qualified so the requester sees one strobe at the single
  // Tick edge that leaves CAPTURE, however slowly Tick runs.
  assign bus.br_ack  = tick && (r_state == ST_CAPTURE) && (r_src == SRC_BR);
  assign bus.irq_ack = tick && (r_state == ST_CAPTURE) && (r_src == SRC_IRQ);
  assign bus.reg_ce  = r_reg_ce;
  assign bus.reg_d   = r_reg_d;
  assign bus.reg_cs  = r_reg_cs;
  assign bus.pc_load = r_pc_load;
  assign bus.flush   = r_flush;
  assign bus.busy    = r_busy;
  assign bus.err     = r_err;

endmodule
`default_nettype wire

// File: doc/branch_addr_ctrl.md
Name: branch_addr_ctrl

Overview:
- Sequencer and arbiter for the branch-instruction-address register of the CPU core.
- Accepts branch-target requests from the branch unit and vector requests from the interrupt unit, and grants one at a time.
- Loads the chosen address into the register via its ClockEnable/D inputs, then enables the register's tri-state output (cs) onto the PC bus and handshakes the PC load.
- After the PC load, holds a pipeline flush for a fixed number of Ticks.

Parameters:
- ADDR_W, 8, width of target/vector address and of the register D.
- FLUSH_CYCLES, 2, Ticks of flush after PC load; 0 skips FLUSH.
- ACK_TIMEOUT, 15, Ticks waited in DRIVE for pc_ack before flagging err.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Tick  in  1  global clock enable; state advances only on rising Clock with Tick=1.
- br_req  in  1  branch request, level, held until br_ack.
- br_target  in  ADDR_W  branch target, stable while br_req=1.
- irq_req  in  1  interrupt request, level, held until irq_ack.
- irq_vector  in  ADDR_W  interrupt vector, stable while irq_req=1.
- br_ack  out  1  grant strobe to branch unit.
- irq_ack  out  1  grant strobe to interrupt unit.
- reg_ce  out  1  drives register ClockEnable.
- reg_d  out  ADDR_W  drives register D.
- reg_cs  out  1  drives register cs; 1 = register output high-Z.
- pc_load  out  1  PC must load from address bus.
- pc_ack  in  1  PC has loaded; level, held until pc_load falls.
- flush  out  1  pipeline flush.
- busy  out  1  state != IDLE.
- err  out  1  sticky pc_ack timeout flag.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE, reg_d=0, src=0, counters=0, err=0.
  - Outputs: reg_cs=1, reg_ce=0, pc_load=0, flush=0, busy=0, br_ack=0, irq_ack=0.
- Ticks: all transitions below occur only on a Clock edge with Tick=1. With Tick=0, all registers hold.
- States: IDLE, CAPTURE, DRIVE, FLUSH.
- IDLE:
  - If irq_req: reg_d<=irq_vector, src<=IRQ, go to CAPTURE.
  - Else if br_req: reg_d<=br_target, src<=BR, go to CAPTURE.
  - Interrupt has fixed priority when both requests are present; the branch request stays pending.
- CAPTURE (exactly one Tick):
  - reg_ce=1; reg_d is stable from the registered value.
  - br_ack = Tick & src==BR; irq_ack = Tick & src==IRQ. The requester sees exactly one qualified strobe.
  - Go to DRIVE; timeout counter <= 0.
- DRIVE:
  - reg_cs=0, pc_load=1.
  - On a Tick with pc_ack=1: go to FLUSH with flush counter <= FLUSH_CYCLES, or go to IDLE if FLUSH_CYCLES=0.
  - Otherwise increment the timeout counter. On reaching ACK_TIMEOUT: set err=1 and go to IDLE.
- FLUSH:
  - flush=1, reg_cs=1.
  - Decrement the counter each Tick; go to IDLE when it reaches 1.
  - flush is high for exactly FLUSH_CYCLES Ticks.
- Output decode: reg_cs=0 only in DRIVE; reg_ce=1 only in CAPTURE. All outputs are Moore except the Tick-qualified acks.
- Latency (all Tick=1): request seen in IDLE to pc_load = 2 Ticks.
- Requests during busy are not acknowledged; they are arbitrated on return to IDLE.
- A request withdrawn before grant is dropped silently.
- Back-to-back: IDLE lasts at least 1 Tick between grants.
- err clears only on Reset. It does not block further operation.

Decomposition:
- Shared package `branch_ctrl_pkg`: state enum (IDLE=0, CAPTURE=1, DRIVE=2, FLUSH=3), src encoding (BR=0, IRQ=1), and the counter-width function clog2.
- One natural sub-module: `tick_down_counter` (loadable, Tick-gated, zero flag), used for both the flush and timeout counters.

Test Plan:
- Branch only, Tick=1, br_target=0x5A, pc_ack returned 1 Tick after pc_load:
  - br_ack pulses 1 Tick after br_req; reg_ce=1 that Tick; reg_d=0x5A.
  - reg_cs=0 and pc_load=1 next Tick.
  - flush high for exactly 2 Ticks, then busy=0.
- Simultaneous irq_req (vector 0x10) and br_req (0x33):
  - irq_ack first; reg_d=0x10.
  - After FLUSH and 1 IDLE Tick, br_ack; reg_d=0x33.
- Tick high one clock in four during the branch-only sequence:
  - State changes only on Tick clocks; br_ack asserts on only one clock; sequence identical to the first scenario in Ticks.
- pc_ack never asserted:
  - After 15 Ticks in DRIVE: err=1, state IDLE, reg_cs=1; err stays 1 through a subsequent normal branch.
- Reset asserted in DRIVE, asynchronously between clock edges:
  - reg_cs=1, pc_load=0, busy=0 immediately, without waiting for a Clock edge.
  - After release, a new br_req is serviced normally.
- FLUSH_CYCLES=0 build:
  - pc_ack goes directly DRIVE→IDLE; flush never asserts.
